// File: rtl/treemux_pkg.sv
// Shared constants, helpers and types for the treemux tree and its sink FIFO.
package treemux_pkg;

  localparam int TM_WIDTH = 72;

  typedef logic [31:0] tm_cnt_t;

  // Address width that never collapses to zero bits for tiny depths.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/treemux_sink_ctrl.sv
// Pointer, occupancy and flag control for the treemux sink FIFO.
// Optional statistics counters are built only when TREEMUX_SINK_STATS_EN is defined.
module treemux_sink_ctrl
  import treemux_pkg::*;
#(
  parameter  int DEPTH        = 16,
  parameter  int AFULL_MARGIN = 4,
  localparam int AW           = clog2_min1(DEPTH),
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          valid_in,
  input  logic          ready_in,
  input  logic          clr_overflow,
  output logic          push,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic          valid_out,
  output logic          almost_full,
  output logic [CW-1:0] count,
  output logic          overflow
`ifdef TREEMUX_SINK_STATS_EN
  ,
  output tm_cnt_t       push_cnt,
  output tm_cnt_t       drop_cnt
`endif
);

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL = CW'(DEPTH - AFULL_MARGIN);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // Handshake: a word transfers on any cycle where valid_out && ready_in;
  // the source side has no ready, so a full FIFO without a pop drops the word.
  assign valid_out   = (r_count != '0);
  assign w_pop       = valid_out && ready_in;
  assign w_push      = valid_in && ((r_count < C_DEPTH) || w_pop);
  assign w_drop      = valid_in && !w_push;
  assign almost_full = (r_count >= C_AFULL);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      // A drop in the same cycle as a clear wins, so no loss goes unreported.
      if (w_drop)            r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

`ifdef TREEMUX_SINK_STATS_EN
  tm_cnt_t r_push_cnt;
  tm_cnt_t r_drop_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_push_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push && (r_push_cnt != '1)) r_push_cnt <= r_push_cnt + 32'd1;
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign push_cnt = r_push_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

  assign push     = w_push;
  assign wr_ptr   = r_wr_ptr;
  assign rd_ptr   = r_rd_ptr;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: rtl/treemux_sink_fifo.sv
// FWFT elastic buffer turning the treemux valid-only stream into valid/ready.
// TREEMUX_SINK_STATS_EN adds push_cnt/drop_cnt statistics outputs.
module treemux_sink_fifo
  import treemux_pkg::*;
#(
  parameter  int WIDTH        = TM_WIDTH,
  parameter  int DEPTH        = 16,
  parameter  int AFULL_MARGIN = 4,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  input  logic             clr_overflow
`ifdef TREEMUX_SINK_STATS_EN
  ,
  output tm_cnt_t          push_cnt,
  output tm_cnt_t          drop_cnt
`endif
);

  localparam int AW = clog2_min1(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic [AW-1:0]    w_wr_ptr;
  logic [AW-1:0]    w_rd_ptr;

  treemux_sink_ctrl #(
    .DEPTH        (DEPTH),
    .AFULL_MARGIN (AFULL_MARGIN)
  ) u_ctrl (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .clr_overflow (clr_overflow),
    .push         (w_push),
    .wr_ptr       (w_wr_ptr),
    .rd_ptr       (w_rd_ptr),
    .valid_out    (valid_out),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow)
`ifdef TREEMUX_SINK_STATS_EN
    ,
    .push_cnt     (push_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  // Storage is deliberately unreset; valid_out masks stale contents.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[w_wr_ptr] <= data_in;
  end

  assign data_out = r_mem[w_rd_ptr];

endmodule

// File: tb/tb_treemux_sink_fifo.sv
// Directed testbench for treemux_sink_fifo with a queue scoreboard and occupancy model.
module tb_treemux_sink_fifo;

  localparam int W  = 72;
  localparam int D  = 16;
  localparam int CW = 5;

  logic          CLK;
  logic          RST_N;
  logic [W-1:0]  data_in;
  logic          valid_in;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic          ready_in;
  logic          almost_full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_overflow;
`ifdef TREEMUX_SINK_STATS_EN
  logic [31:0]   push_cnt;
  logic [31:0]   drop_cnt;
  int            m_push_cnt;
  int            m_drop_cnt;
`endif

  logic [W-1:0]  exp_q[$];
  logic          m_ovf;
  int            n_checks;
  int            n_errors;

  treemux_sink_fifo dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef TREEMUX_SINK_STATS_EN
    ,
    .push_cnt     (push_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ovf = 1'b0;
`ifdef TREEMUX_SINK_STATS_EN
    m_push_cnt = 0;
    m_drop_cnt = 0;
`endif
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_count"}, W'(count), W'(exp_q.size()));
    check_eq({tag, "_valid"}, W'(valid_out), W'(exp_q.size() != 0));
    check_eq({tag, "_afull"}, W'(almost_full), W'(exp_q.size() >= D - 4));
    check_eq({tag, "_ovf"}, W'(overflow), W'(m_ovf));
  endtask

  // driver: one clock cycle of stimulus, model update before the edge, state check after it
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic clr,
                      input string tag);
    int  cnt_before;
    logic do_pop;
    logic do_push;
    valid_in     = v;
    data_in      = d;
    ready_in     = r;
    clr_overflow = clr;
    #1;
    cnt_before = exp_q.size();
    do_pop     = (cnt_before != 0) && r;
    do_push    = v && ((cnt_before < D) || do_pop);
    if (do_pop) check_eq({tag, "_pop_data"}, data_out, exp_q.pop_front());
    if (do_push) exp_q.push_back(d);
    if (v && !do_push) m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
`ifdef TREEMUX_SINK_STATS_EN
    if (do_push) m_push_cnt++;
    if (v && !do_push) m_drop_cnt++;
`endif
    @(posedge CLK);
    #1;
    valid_in     = 1'b0;
    ready_in     = 1'b0;
    clr_overflow = 1'b0;
    check_state(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * D && exp_q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0, tag);
    check_eq({tag, "_drained"}, W'(exp_q.size()), W'(0));
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    RST_N        = 1'b0;
    valid_in     = 1'b0;
    ready_in     = 1'b0;
    clr_overflow = 1'b0;
    data_in      = '0;
    model_clear();
    #12 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check_eq("rst_count", W'(count), W'(0));
    check_eq("rst_valid", W'(valid_out), W'(0));
    check_eq("rst_afull", W'(almost_full), W'(0));
    check_eq("rst_ovf", W'(overflow), W'(0));

    // 1) single push, held while ready_in=0
    step(1'b1, 72'hA5, 1'b0, 1'b0, "t1_push");
    check_eq("t1_data", data_out, 72'hA5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, "t1_hold");
      check_eq("t1_hold_data", data_out, 72'hA5);
    end
    step(1'b0, '0, 1'b1, 1'b0, "t1_pop");

    // 2) fill to DEPTH; almost_full rises at count 12
    for (int i = 0; i < D; i++) step(1'b1, W'(i), 1'b0, 1'b0, "t2_fill");
    check_eq("t2_full_count", W'(count), W'(16));
    check_eq("t2_afull", W'(almost_full), W'(1));

    // 3) push into full FIFO: dropped, sticky overflow, head unchanged
    step(1'b1, 72'hDEAD, 1'b0, 1'b0, "t3_drop");
    check_eq("t3_ovf", W'(overflow), W'(1));
    check_eq("t3_head", data_out, W'(0));
`ifdef TREEMUX_SINK_STATS_EN
    check_eq("t3_drop_cnt", W'(drop_cnt), W'(1));
`endif
    step(1'b0, '0, 1'b0, 1'b1, "t3_clr");
    check_eq("t3_ovf_clr", W'(overflow), W'(0));

    // 4) full with simultaneous push and pop: accepted, order kept 0..16
    step(1'b1, W'(16), 1'b1, 1'b0, "t4_push_pop");
    check_eq("t4_count", W'(count), W'(16));
    check_eq("t4_ovf", W'(overflow), W'(0));
    drain("t4_drain");

    // empty with ready_in: no pop, no underflow
    step(1'b0, '0, 1'b1, 1'b0, "t4_empty_rdy");

    // 5) random push/pop traffic across pointer wrap
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), {8'($urandom), $urandom, $urandom},
           1'($urandom_range(0, 1)), 1'b0, "t5_rand");
    drain("t5_drain");

    // 6) async reset mid-stream with 7 entries
    for (int i = 0; i < 7; i++) step(1'b1, W'(100 + i), 1'b0, 1'b0, "t6_fill");
    check_eq("t6_pre_count", W'(count), W'(7));
    RST_N = 1'b0;
    #1;
    check_eq("t6_rst_valid", W'(valid_out), W'(0));
    check_eq("t6_rst_count", W'(count), W'(0));
    model_clear();
    #2 RST_N = 1'b1;
    @(posedge CLK);
    #1;
    step(1'b1, 72'h123456789ABCDEF012, 1'b0, 1'b0, "t6_push");
    check_eq("t6_data", data_out, 72'h123456789ABCDEF012);
    step(1'b0, '0, 1'b1, 1'b0, "t6_pop");

`ifdef TREEMUX_SINK_STATS_EN
    check_eq("stats_push_cnt", W'(push_cnt), W'(m_push_cnt));
    check_eq("stats_drop_cnt", W'(drop_cnt), W'(m_drop_cnt));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
